atm_auth_ctrl: RTL and testbench
================================

Name: atm_auth_ctrl

Overview:
Sequences customer PIN authentication between card insertion and the transaction menu.
- Captures the keypad password on `enter` and waits for the card handler's stored password.
- Compares the two, counts failed attempts and retains the card after the last failure.
- Enforces a keypad inactivity timeout, then grants or ends the session.
- Sits between the card handler and the main ATM state machine.

Parameters:
- PASSWORD_SIZE, 16, width of entered and stored password.
- MAX_TRIES, 3, failed attempts allowed before card retention (1..7).
- TIMEOUT_CYC, 1000, inactivity limit in clk cycles (>=2).
- TMR_W, 10, timer width; must satisfy 2**TMR_W >= TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset: one clock; reset is synchronous and active-high (rst_n=1 resets; port name kept per codebase naming).
- start  input  1  card inserted and accepted; honoured in IDLE only.
- enter  input  1  keypad enter strobe.
- cancel  input  1  customer cancel.
- end_session  input  1  main FSM finished the transaction.
- input_password  input  PASSWORD_SIZE  keypad value, sampled on enter.
- stored_password  input  PASSWORD_SIZE  card handler's password.
- stored_valid  input  1  stored_password valid this cycle.
- busy  output  1  state != IDLE.
- auth_ok  output  1  level, high in SESSION.
- wrong_pw  output  1  1-cycle pulse, mismatch with tries remaining.
- card_retain  output  1  1-cycle pulse, last try failed.
- abort  output  1  1-cycle pulse, cancel accepted.
- timeout  output  1  1-cycle pulse, inactivity expiry.
- tries_left  output  3  remaining attempts.
- state_out  output  3  encoded state, for debug and coverage.

Behaviour:
- All outputs are registered and change on the clk edge that changes state.
- Reset values:
  - state=IDLE; captured password=0; timer=0; tries_left=MAX_TRIES.
  - busy, auth_ok, wrong_pw, card_retain, abort and timeout are all 0.
- Reset mid-operation: any state goes to IDLE on the next edge, with no pulses.
- States and encoding: IDLE=0, WAIT_PW=1, CHECK=2, SESSION=3, RETAIN=4.
- IDLE:
  - start=1 -> WAIT_PW, tries_left=MAX_TRIES, timer=0.
  - enter, cancel and end_session are ignored.
- WAIT_PW: per-cycle priority is cancel > timeout > enter > else.
  - cancel -> IDLE with abort pulse.
  - timer==TIMEOUT_CYC-1 -> IDLE with timeout pulse.
  - enter -> capture input_password, go to CHECK, timer=0.
  - otherwise the timer increments.
- CHECK:
  - The timer does not run.
  - cancel -> IDLE with abort pulse (cancel wins over a same-cycle stored_valid).
  - Otherwise, on stored_valid=1, compare the full width of captured vs stored:
    - equal -> SESSION; tries_left is held.
    - unequal and tries_left>1 -> tries_left-1, go to WAIT_PW, timer=0, wrong_pw pulse.
    - unequal and tries_left==1 -> tries_left=0, go to RETAIN, card_retain pulse.
  - stored_valid=0 -> stay in CHECK.
- SESSION:
  - auth_ok=1 throughout.
  - Priority: end_session > cancel > timeout.
    - end_session -> IDLE.
    - cancel -> IDLE with abort pulse.
    - Inactivity: the timer resets on enter; timer==TIMEOUT_CYC-1 -> IDLE with timeout pulse.
- RETAIN: one cycle only, then unconditionally IDLE; tries_left returns to MAX_TRIES on entering IDLE.
- start outside IDLE is ignored. Timer arithmetic saturates and never wraps.
- Pulses are mutually exclusive and each lasts exactly one cycle.

Decomposition:
- Shared package `param`:
  - `auth_state_e` enum, 3-bit.
  - Default constants AUTH_MAX_TRIES and AUTH_TIMEOUT_CYC.
  - Reuse of the existing PASSWORD_SIZE.
- One sub-module: `atm_inactivity_timer`, a clear/enable counter with expiry flag parameterised by TIMEOUT_CYC and TMR_W.
- FSM and compare logic stay in atm_auth_ctrl.

Test Plan:
All scenarios use TIMEOUT_CYC=8 and MAX_TRIES=3.
1. Correct PIN: start; enter with input 16'h1234; stored 16'h1234 with stored_valid=1 -> auth_ok=1 the cycle after stored_valid, tries_left=3; end_session -> IDLE, busy=0.
2. Two wrong PINs, then correct: 16'h1111 and 16'h2222 vs stored 16'h1234 -> two wrong_pw pulses, tries_left 3->2->1; then 16'h1234 -> SESSION with tries_left=1.
3. Three wrong PINs -> wrong_pw, wrong_pw, card_retain (one cycle), state_out 4 then 0, tries_left=3 in IDLE.
4. Timeout: start, no enter for 8 cycles -> timeout pulse on the 8th WAIT_PW cycle, IDLE. In SESSION, enter every 5 cycles -> no timeout.
5. Simultaneous events:
   - cancel and enter in the same WAIT_PW cycle -> abort, no CHECK.
   - cancel and stored_valid (match) in CHECK -> abort, auth_ok stays 0.
   - end_session and cancel in SESSION -> IDLE, no abort.
6. Reset mid-CHECK: rst_n=1 for 1 cycle -> IDLE, all outputs 0, tries_left=3; start while busy is ignored.

Source files
------------

// File: rtl/atm_auth_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// param : shared definitions for the ATM PIN authentication slice.
//
// Contents
//   auth_state_e      3-bit FSM state encoding, also exported on state_out
//   PASSWORD_SIZE     width of keypad / card-handler passwords
//   AUTH_MAX_TRIES    default failed attempts allowed before card retention
//   AUTH_TIMEOUT_CYC  default keypad inactivity limit in clk cycles
//   AUTH_TMR_W        default inactivity timer width
// -----------------------------------------------------------------------------
package param;

    localparam int PASSWORD_SIZE    = 16;
    localparam int AUTH_MAX_TRIES   = 3;
    localparam int AUTH_TIMEOUT_CYC = 1000;
    localparam int AUTH_TMR_W       = 10;

    // Encoding is visible on state_out, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PW = 3'd1,
        ST_CHECK   = 3'd2,
        ST_SESSION = 3'd3,
        ST_RETAIN  = 3'd4
    } auth_state_e;

endpackage : param

// File: rtl/atm_auth_ctrl_timer.sv
// -----------------------------------------------------------------------------
// atm_inactivity_timer : clear/enable up-counter with an expiry flag.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-high reset (name kept from the codebase)
//   clr      force the count to zero on the next edge (wins over en)
//   en       advance the count by one on the next edge
//   expired  count has reached TIMEOUT_CYC-1
//
// The count saturates at its all-ones value and never wraps, so an
// enable held past expiry cannot re-arm the timer by rolling over.
// -----------------------------------------------------------------------------
module atm_inactivity_timer #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TMR_W       = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] SAT_CNT  = {TMR_W{1'b1}};

    logic [TMR_W-1:0] count_r;

    // Inactivity counter: reset/clear to zero, saturating increment when enabled.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_r <= {TMR_W{1'b0}};
        end else if (clr) begin
            count_r <= {TMR_W{1'b0}};
        end else if (en && (count_r != SAT_CNT)) begin
            count_r <= count_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST_CNT);

endmodule : atm_inactivity_timer

// File: rtl/atm_auth_ctrl.sv
// -----------------------------------------------------------------------------
// atm_auth_ctrl : PIN authentication sequencer between card insertion and
// the transaction menu.
//
// Ports
//   clk, rst_n        clock and synchronous active-high reset (rst_n=1 resets)
//   start             card accepted; honoured in IDLE only
//   enter             keypad enter strobe, samples input_password
//   cancel            customer cancel
//   end_session       main FSM finished the transaction
//   input_password    keypad value
//   stored_password   card handler's password, qualified by stored_valid
//   busy              state != IDLE
//   auth_ok           level, high while in SESSION
//   wrong_pw          pulse: mismatch with tries remaining
//   card_retain       pulse: last try failed
//   abort             pulse: cancel accepted
//   timeout           pulse: inactivity expiry
//   tries_left        remaining attempts
//   state_out         encoded state (IDLE=0 WAIT_PW=1 CHECK=2 SESSION=3 RETAIN=4)
//
// Every output is a register updated on the same edge as the state.
// -----------------------------------------------------------------------------
module atm_auth_ctrl
    import param::auth_state_e, param::ST_IDLE, param::ST_WAIT_PW,
           param::ST_CHECK, param::ST_SESSION, param::ST_RETAIN;
#(
    parameter int PASSWORD_SIZE = param::PASSWORD_SIZE,
    parameter int MAX_TRIES     = param::AUTH_MAX_TRIES,
    parameter int TIMEOUT_CYC   = param::AUTH_TIMEOUT_CYC,
    parameter int TMR_W         = param::AUTH_TMR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     enter,
    input  logic                     cancel,
    input  logic                     end_session,
    input  logic [PASSWORD_SIZE-1:0] input_password,
    input  logic [PASSWORD_SIZE-1:0] stored_password,
    input  logic                     stored_valid,
    output logic                     busy,
    output logic                     auth_ok,
    output logic                     wrong_pw,
    output logic                     card_retain,
    output logic                     abort,
    output logic                     timeout,
    output logic [2:0]               tries_left,
    output logic [2:0]               state_out
);

    localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);

    auth_state_e              state_r;
    logic [PASSWORD_SIZE-1:0] captured_pw_r;
    logic [2:0]               tries_r;
    logic                     busy_r;
    logic                     auth_ok_r;
    logic                     wrong_pw_r;
    logic                     card_retain_r;
    logic                     abort_r;
    logic                     timeout_r;

    logic                     tmr_clr_s;
    logic                     tmr_en_s;
    logic                     tmr_expired_s;

    atm_inactivity_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Timer control: counts only while waiting for keypad activity; any
    // event that leaves or re-arms the waiting state clears it.
    always_comb begin
        tmr_clr_s = 1'b1;
        tmr_en_s  = 1'b0;
        case (state_r)
            ST_WAIT_PW: begin
                if (cancel || tmr_expired_s || enter) begin
                    tmr_clr_s = 1'b1;
                end else begin
                    tmr_clr_s = 1'b0;
                    tmr_en_s  = 1'b1;
                end
            end
            ST_SESSION: begin
                if (end_session || cancel || tmr_expired_s || enter) begin
                    tmr_clr_s = 1'b1;
                end else begin
                    tmr_clr_s = 1'b0;
                    tmr_en_s  = 1'b1;
                end
            end
            default: begin
                tmr_clr_s = 1'b1;
                tmr_en_s  = 1'b0;
            end
        endcase
    end

    // Authentication FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r       <= ST_IDLE;
            captured_pw_r <= {PASSWORD_SIZE{1'b0}};
            tries_r       <= TRIES_INIT;
            busy_r        <= 1'b0;
            auth_ok_r     <= 1'b0;
            wrong_pw_r    <= 1'b0;
            card_retain_r <= 1'b0;
            abort_r       <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            wrong_pw_r    <= 1'b0;
            card_retain_r <= 1'b0;
            abort_r       <= 1'b0;
            timeout_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    auth_ok_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_WAIT_PW;
                        busy_r  <= 1'b1;
                        tries_r <= TRIES_INIT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT_PW: begin
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        abort_r <= 1'b1;
                    end else if (tmr_expired_s) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                    end else if (enter) begin
                        state_r       <= ST_CHECK;
                        captured_pw_r <= input_password;
                    end else begin
                        state_r <= ST_WAIT_PW;
                    end
                end
                ST_CHECK: begin
                    // cancel is checked first so a late stored_valid cannot grant access
                    if (cancel) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        abort_r <= 1'b1;
                    end else if (stored_valid) begin
                        if (captured_pw_r == stored_password) begin
                            state_r   <= ST_SESSION;
                            auth_ok_r <= 1'b1;
                        end else if (tries_r > 3'd1) begin
                            state_r    <= ST_WAIT_PW;
                            tries_r    <= tries_r - 3'd1;
                            wrong_pw_r <= 1'b1;
                        end else begin
                            state_r       <= ST_RETAIN;
                            tries_r       <= 3'd0;
                            card_retain_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_SESSION: begin
                    if (end_session) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        auth_ok_r <= 1'b0;
                    end else if (cancel) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        auth_ok_r <= 1'b0;
                        abort_r   <= 1'b1;
                    end else if (tmr_expired_s) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        auth_ok_r <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_SESSION;
                    end
                end
                ST_RETAIN: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    auth_ok_r <= 1'b0;
                    tries_r   <= TRIES_INIT;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    auth_ok_r <= 1'b0;
                    tries_r   <= TRIES_INIT;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign auth_ok     = auth_ok_r;
    assign wrong_pw    = wrong_pw_r;
    assign card_retain = card_retain_r;
    assign abort       = abort_r;
    assign timeout     = timeout_r;
    assign tries_left  = tries_r;
    assign state_out   = state_r;

endmodule : atm_auth_ctrl

// File: tb/tb_atm_auth_ctrl.sv
module tb_atm_auth_ctrl;

    localparam int PW = 16;
    localparam int MT = 3;
    localparam int TC = 8;
    localparam int TW = 4;

    // reference phases, numbered as exported on state_out
    localparam int PH_IDLE    = 0;
    localparam int PH_WAIT    = 1;
    localparam int PH_CHECK   = 2;
    localparam int PH_SESSION = 3;
    localparam int PH_RETAIN  = 4;

    logic          clk = 1'b0;
    logic          rst_n, start, enter, cancel, end_session, stored_valid;
    logic [PW-1:0] input_password, stored_password;
    logic          busy, auth_ok, wrong_pw, card_retain, abort, timeout;
    logic [2:0]    tries_left, state_out;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: phase, idle cycles observed, failed attempts, held PIN
    int            m_phase;
    int            m_quiet;
    int            m_fails;
    logic [PW-1:0] m_pin;
    bit            m_wrong, m_retain, m_abort, m_tmo;

    always #5 clk = ~clk;

    atm_auth_ctrl #(
        .PASSWORD_SIZE (PW),
        .MAX_TRIES     (MT),
        .TIMEOUT_CYC   (TC),
        .TMR_W         (TW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .enter           (enter),
        .cancel          (cancel),
        .end_session     (end_session),
        .input_password  (input_password),
        .stored_password (stored_password),
        .stored_valid    (stored_valid),
        .busy            (busy),
        .auth_ok         (auth_ok),
        .wrong_pw        (wrong_pw),
        .card_retain     (card_retain),
        .abort           (abort),
        .timeout         (timeout),
        .tries_left      (tries_left),
        .state_out       (state_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the specification's rules for one clock edge to the model.
    task automatic model_step();
        m_wrong  = 1'b0;
        m_retain = 1'b0;
        m_abort  = 1'b0;
        m_tmo    = 1'b0;
        if (rst_n) begin
            m_phase = PH_IDLE; m_quiet = 0; m_fails = 0; m_pin = '0;
        end else if (m_phase == PH_IDLE) begin
            if (start) begin
                m_phase = PH_WAIT; m_quiet = 0; m_fails = 0;
            end
        end else if (m_phase == PH_WAIT) begin
            if (cancel) begin
                m_phase = PH_IDLE; m_abort = 1'b1;
            end else if (m_quiet == TC - 1) begin
                m_phase = PH_IDLE; m_tmo = 1'b1;
            end else if (enter) begin
                m_pin = input_password; m_phase = PH_CHECK; m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end else if (m_phase == PH_CHECK) begin
            if (cancel) begin
                m_phase = PH_IDLE; m_abort = 1'b1;
            end else if (stored_valid) begin
                if (m_pin == stored_password) begin
                    m_phase = PH_SESSION; m_quiet = 0;
                end else if (MT - m_fails > 1) begin
                    m_fails++; m_phase = PH_WAIT; m_quiet = 0; m_wrong = 1'b1;
                end else begin
                    m_fails = MT; m_phase = PH_RETAIN; m_retain = 1'b1;
                end
            end
        end else if (m_phase == PH_SESSION) begin
            if (end_session) begin
                m_phase = PH_IDLE;
            end else if (cancel) begin
                m_phase = PH_IDLE; m_abort = 1'b1;
            end else if (m_quiet == TC - 1) begin
                m_phase = PH_IDLE; m_tmo = 1'b1;
            end else if (enter) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
        end else begin
            m_phase = PH_IDLE; m_fails = 0;
        end
    endtask

    task automatic check_all();
        chk("state_out",   state_out,   m_phase);
        chk("busy",        busy,        (m_phase != PH_IDLE) ? 1 : 0);
        chk("auth_ok",     auth_ok,     (m_phase == PH_SESSION) ? 1 : 0);
        chk("wrong_pw",    wrong_pw,    m_wrong);
        chk("card_retain", card_retain, m_retain);
        chk("abort",       abort,       m_abort);
        chk("timeout",     timeout,     m_tmo);
        chk("tries_left",  tries_left,  MT - m_fails);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic quiet_inputs();
        rst_n = 1'b0; start = 1'b0; enter = 1'b0; cancel = 1'b0;
        end_session = 1'b0; stored_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic attempt(input logic [PW-1:0] typed, input logic [PW-1:0] card);
        input_password = typed; enter = 1'b1; step(); enter = 1'b0;
        stored_password = card; stored_valid = 1'b1; step(); stored_valid = 1'b0;
    endtask

    initial begin
        quiet_inputs();
        input_password = '0;
        stored_password = '0;
        m_phase = PH_IDLE; m_quiet = 0; m_fails = 0; m_pin = '0;

        // reset state
        rst_n = 1'b1; step(); step(); rst_n = 1'b0;
        chk("rst_state", state_out, 0);
        chk("rst_tries", tries_left, 3);

        // 1: correct PIN, then end of session
        do_start();
        attempt(16'h1234, 16'h1234);
        chk("sc1_auth_ok", auth_ok, 1);
        chk("sc1_tries", tries_left, 3);
        end_session = 1'b1; step(); end_session = 1'b0;
        chk("sc1_busy", busy, 0);

        // 2: two wrong PINs, then correct
        do_start();
        attempt(16'h1111, 16'h1234);
        chk("sc2_wrong1", wrong_pw, 1);
        chk("sc2_tries2", tries_left, 2);
        attempt(16'h2222, 16'h1234);
        chk("sc2_wrong2", wrong_pw, 1);
        chk("sc2_tries1", tries_left, 1);
        attempt(16'h1234, 16'h1234);
        chk("sc2_session", state_out, 3);
        chk("sc2_tries_held", tries_left, 1);
        end_session = 1'b1; step(); end_session = 1'b0;

        // 3: three wrong PINs -> card retention
        do_start();
        attempt(16'h1111, 16'h1234);
        attempt(16'h2222, 16'h1234);
        attempt(16'h3333, 16'h1234);
        chk("sc3_retain", card_retain, 1);
        chk("sc3_state4", state_out, 4);
        step();
        chk("sc3_retain_done", card_retain, 0);
        chk("sc3_idle", state_out, 0);
        chk("sc3_tries_rearm", tries_left, 3);

        // 4: WAIT_PW inactivity timeout, then SESSION kept alive by enter
        do_start();
        for (int i = 0; i < TC - 1; i++) step();
        chk("sc4_no_tmo_yet", timeout, 0);
        step();
        chk("sc4_timeout", timeout, 1);
        chk("sc4_idle", state_out, 0);
        do_start();
        attempt(16'h00ab, 16'h00ab);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) step();
            enter = 1'b1; step(); enter = 1'b0;
        end
        chk("sc4_session_alive", state_out, 3);
        end_session = 1'b1; step(); end_session = 1'b0;

        // 5: simultaneous events
        do_start();
        input_password = 16'h4444; enter = 1'b1; cancel = 1'b1; step();
        enter = 1'b0; cancel = 1'b0;
        chk("sc5a_abort", abort, 1);
        chk("sc5a_idle", state_out, 0);
        do_start();
        input_password = 16'h5555; enter = 1'b1; step(); enter = 1'b0;
        stored_password = 16'h5555; stored_valid = 1'b1; cancel = 1'b1; step();
        stored_valid = 1'b0; cancel = 1'b0;
        chk("sc5b_abort", abort, 1);
        chk("sc5b_no_auth", auth_ok, 0);
        do_start();
        attempt(16'h6666, 16'h6666);
        end_session = 1'b1; cancel = 1'b1; step();
        end_session = 1'b0; cancel = 1'b0;
        chk("sc5c_no_abort", abort, 0);
        chk("sc5c_idle", state_out, 0);

        // 6: reset mid-CHECK, then start ignored while busy
        do_start();
        input_password = 16'h7777; enter = 1'b1; step(); enter = 1'b0;
        rst_n = 1'b1; step(); rst_n = 1'b0;
        chk("sc6_idle", state_out, 0);
        chk("sc6_busy", busy, 0);
        chk("sc6_tries", tries_left, 3);
        do_start();
        attempt(16'h1111, 16'h7777);
        start = 1'b1; step(); start = 1'b0;
        chk("sc6_start_ignored_tries", tries_left, 2);
        chk("sc6_start_ignored_state", state_out, 1);
        cancel = 1'b1; step(); cancel = 1'b0;

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 99) < 20);
            enter        = ($urandom_range(0, 99) < 15);
            cancel       = ($urandom_range(0, 99) < 3);
            end_session  = ($urandom_range(0, 99) < 2);
            stored_valid = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
                0:       input_password = 16'h1234;
                1:       input_password = 16'h8001;
                default: input_password = 16'($urandom);
            endcase
            stored_password = ($urandom_range(0, 1) == 0) ? 16'h1234 : 16'h8001;
            step();
        end
        quiet_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_atm_auth_ctrl
